pe_conv_sequencer: RTL
======================

// Module: pe_conv_sequencer
// PURPOSE
// - Synchronous scheduler for one PE's 1-D spike convolution. Holds one filter row, accepts one ifmap row per pass.
// - Steps all window positions x filter taps, one tap per clock, and accumulates each window's partial sum.
// - Emits each psum tagged with a rotating adder-node destination, then forwards the ifmap row to the neighbour PE.
// - Sits between the PE depacketizer (filter/ifmap in) and the packetizer (psum/forward out).
// PARAMETERS
// - IFMAP_LEN    25       spike bits per ifmap row
// - FILT_TAPS    5        filter taps per row
// - W_WIDTH      8        bits per filter weight (unsigned)
// - PSUM_WIDTH   13       psum/accumulator width
// - ADDR_WIDTH   4        NoC node address width
// - NUM_ADDERS   7        entries in the destination adder table
// - PE_ADDR      4'b0000  this PE's node address, driven on psum_src
// PORTS
// - clk          in   1                     clock, rising edge
// - rst_n        in   1                     asynchronous active-low reset
// - filt_valid   in   1                     filter row offered
// - filt_data    in   FILT_TAPS*W_WIDTH     tap k = filt_data[k*W_WIDTH +: W_WIDTH]
// - filt_ready   out  1                     filter row accepted when valid&ready
// - ifmap_valid  in   1                     ifmap row offered
// - ifmap_data   in   IFMAP_LEN             spike j = ifmap_data[j]
// - ifmap_ready  out  1                     ifmap row accepted when valid&ready
// - psum_valid   out  1                     psum offered to packetizer
// - psum_data    out  PSUM_WIDTH            window partial sum
// - psum_dst     out  ADDR_WIDTH            destination adder node
// - psum_src     out  ADDR_WIDTH            constant PE_ADDR
// - psum_ready   in   1                     packetizer accepts psum
// - fwd_valid    out  1                     ifmap row offered to neighbour PE
// - fwd_data     out  IFMAP_LEN             forwarded ifmap row (unmodified)
// - fwd_ready    in   1                     neighbour accepts row
// - busy         out  1                     high in any state except IDLE
// - row_done     out  1                     one-cycle pulse when a row pass completes
// BEHAVIOUR
// - NWIN = IFMAP_LEN-FILT_TAPS+1 (21). Window p, tap k: acc += ifmap[p+k] ? w[k] : 0, zero-extended to PSUM_WIDTH; no overflow at defaults (max 1275).
// - Reset: all outputs 0; filt_loaded=0; pos=0; tap=0; acc=0; dst_cnt=0; state=IDLE.
// - States: IDLE -> MAC -> EMIT -> (MAC | FWD | IDLE) -> IDLE.
// - IDLE: filt_ready=1. ifmap_ready = filt_loaded & ~filt_valid (filter has priority on simultaneous offer; ifmap taken a later cycle).
// - IDLE: filter accept latches weights and sets filt_loaded; the filter persists across rows until replaced (only in IDLE).
// - IDLE: ifmap accept latches the row, clears acc/pos/tap, -> MAC next cycle.
// - MAC: exactly FILT_TAPS cycles per window, tap 0..FILT_TAPS-1; after the last tap -> EMIT with the final sum.
// - EMIT: psum_valid=1; psum_data, psum_dst held stable until psum_ready. psum_dst = table[dst_cnt].
// - Table {4'b0010,4'b0110,4'b1011,4'b1111,4'b1110,4'b1001,4'b1101}; dst_cnt wraps NUM_ADDERS-1 -> 0.
// - dst_cnt is never cleared between rows; only reset clears it.
// - EMIT on handshake: dst_cnt++; acc=0; pos++. pos<NWIN -> MAC; pos==NWIN -> FWD.
// - Latency: first psum_valid 1+FILT_TAPS cycles after ifmap accept. Full pass = NWIN*(FILT_TAPS+1) cycles plus stalls.
// - FWD: fwd_valid=1, fwd_data=latched row, held until fwd_ready; then row_done pulses and state -> IDLE.
// - filt_ready=ifmap_ready=0 outside IDLE; busy=1 outside IDLE.
// - Async reset mid-pass aborts it: no further psum/fwd; the filter must be reloaded before the next ifmap is accepted.
// CONFIGURATION
// - IFMAP_FWD_EN defined: FWD state present as above.
// - IFMAP_FWD_EN undefined: no FWD state; fwd_valid=0, fwd_data=0 constantly.
// - Without IFMAP_FWD_EN, the last EMIT handshake pulses row_done and -> IDLE.
// TESTING
// - All weights 1, ifmap all 1s -> 21 psums of 5; dst 2,6,11,15,14,9,13 repeating; fwd_data=25'h1FFFFFF; one row_done.
// - w={10,20,30,40,50} (tap0..4), ifmap=25'h1 -> psum[0]=10, psum[1..20]=0.
// - ifmap bit 4 only -> psum[0]=50, [1]=40, [2]=30, [3]=20, [4]=10, rest 0.
// - psum_ready low 10 cycles at window 3 -> psum_valid/data/dst stable throughout; no psum lost or duplicated.
// - Second ifmap row, same filter -> filter reused; first dst=4'b0010 (21 mod 7 = 0); then a mid-table check: reset after 9 psums, next row first dst=4'b0010.
// - filt_valid & ifmap_valid together in IDLE -> filter taken first, ifmap the next cycle.
// - rst_n low during MAC -> all outputs 0 at once, ifmap_ready=0 until filter reloaded.
// - Build without IFMAP_FWD_EN -> fwd_valid never high; row_done the cycle after the 21st psum handshake.

Source files
------------

// File: rtl/pe_conv_sequencer.sv
// pe_conv_sequencer
//   Scheduler for one PE's 1-D spike convolution.
//   - Holds one filter row (FILT_TAPS unsigned weights).
//   - Accepts one ifmap row (IFMAP_LEN spike bits) per pass.
//   - For each of the NWIN window positions it steps one filter tap per clock
//     and accumulates that window's partial sum.
//   - Each finished psum is offered to the packetizer, tagged with a rotating
//     adder-node destination taken from a fixed table.
//   - After the last window it forwards the unmodified ifmap row to the
//     neighbour PE, then returns to IDLE.
//
// Build option: define IFMAP_FWD_EN to include the FWD state. Without it,
//   fwd_valid and fwd_data are tied to 0 and the pass ends on the last psum
//   handshake.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   filt_valid/filt_data/filt_ready      filter row in; tap k at [k*W_WIDTH +: W_WIDTH]
//   ifmap_valid/ifmap_data/ifmap_ready   ifmap row in; spike j at bit j
//   psum_valid/psum_data/psum_dst/psum_src/psum_ready   psum out to packetizer
//   fwd_valid/fwd_data/fwd_ready         ifmap row out to neighbour PE
//   busy                          high in any state except IDLE
//   row_done                      one-cycle pulse after a row pass completes
module pe_conv_sequencer #(
    parameter int IFMAP_LEN  = 25,
    parameter int FILT_TAPS  = 5,
    parameter int W_WIDTH    = 8,
    parameter int PSUM_WIDTH = 13,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_ADDERS = 7,
    parameter logic [ADDR_WIDTH-1:0] PE_ADDR = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           filt_valid,
    input  logic [FILT_TAPS*W_WIDTH-1:0]   filt_data,
    output logic                           filt_ready,
    input  logic                           ifmap_valid,
    input  logic [IFMAP_LEN-1:0]           ifmap_data,
    output logic                           ifmap_ready,
    output logic                           psum_valid,
    output logic [PSUM_WIDTH-1:0]          psum_data,
    output logic [ADDR_WIDTH-1:0]          psum_dst,
    output logic [ADDR_WIDTH-1:0]          psum_src,
    input  logic                           psum_ready,
    output logic                           fwd_valid,
    output logic [IFMAP_LEN-1:0]           fwd_data,
    input  logic                           fwd_ready,
    output logic                           busy,
    output logic                           row_done
);

    localparam int NWIN  = IFMAP_LEN - FILT_TAPS + 1;
    localparam int POS_W = $clog2(NWIN + 1);
    localparam int TAP_W = (FILT_TAPS > 1) ? $clog2(FILT_TAPS) : 1;
    localparam int DST_W = (NUM_ADDERS > 1) ? $clog2(NUM_ADDERS) : 1;
    localparam int IDX_W = POS_W + 1;

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NWIN - 1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(FILT_TAPS - 1);
    localparam logic [DST_W-1:0] LAST_DST = DST_W'(NUM_ADDERS - 1);

`ifdef IFMAP_FWD_EN
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_FWD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT} state_t;
`endif

    // Destination adder-node table, visited in order and wrapping.
    function automatic logic [ADDR_WIDTH-1:0] dst_lookup(input logic [DST_W-1:0] idx);
        logic [ADDR_WIDTH-1:0] node;
        case (idx)
            DST_W'(0): node = ADDR_WIDTH'(4'b0010);
            DST_W'(1): node = ADDR_WIDTH'(4'b0110);
            DST_W'(2): node = ADDR_WIDTH'(4'b1011);
            DST_W'(3): node = ADDR_WIDTH'(4'b1111);
            DST_W'(4): node = ADDR_WIDTH'(4'b1110);
            DST_W'(5): node = ADDR_WIDTH'(4'b1001);
            DST_W'(6): node = ADDR_WIDTH'(4'b1101);
            default:   node = '0;
        endcase
        return node;
    endfunction

    // One tap contribution: the weight, zero-extended, gated by the spike.
    function automatic logic [PSUM_WIDTH-1:0] tap_term(input logic spike,
                                                       input logic [W_WIDTH-1:0] w);
        return spike ? PSUM_WIDTH'(w) : '0;
    endfunction

    state_t                 state, state_nx;
    logic [W_WIDTH-1:0]     weight [FILT_TAPS];
    logic [IFMAP_LEN-1:0]   row_q;
    logic [PSUM_WIDTH-1:0]  acc;
    logic [POS_W-1:0]       pos;
    logic [TAP_W-1:0]       tap;
    logic [DST_W-1:0]       dst_cnt;
    logic                   filt_loaded;
    // Low while reset is held so every output reads 0 during reset; goes
    // high on the first clock after release and stays high.
    logic                   out_en;

    logic                   filt_take, ifmap_take, psum_take, pass_end;
    logic [IDX_W-1:0]       spike_idx;
    logic                   spike;

    assign spike_idx = IDX_W'(pos) + IDX_W'(tap);
    assign spike     = row_q[spike_idx];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, handshakes and status
    always_comb begin
        state_nx    = state;
        filt_ready  = 1'b0;
        ifmap_ready = 1'b0;
        psum_valid  = 1'b0;
        fwd_valid   = 1'b0;
        busy        = 1'b1;
        filt_take   = 1'b0;
        ifmap_take  = 1'b0;
        psum_take   = 1'b0;
        pass_end    = 1'b0;
        case (state)
            S_IDLE: begin
                busy        = 1'b0;
                filt_ready  = out_en;
                // Filter wins a simultaneous offer; ifmap waits a cycle.
                ifmap_ready = out_en & filt_loaded & ~filt_valid;
                filt_take   = filt_valid & filt_ready;
                ifmap_take  = ifmap_valid & ifmap_ready;
                if (ifmap_take) begin
                    state_nx = S_MAC;
                end
            end
            S_MAC: begin
                if (tap == LAST_TAP) begin
                    state_nx = S_EMIT;
                end
            end
            S_EMIT: begin
                psum_valid = 1'b1;
                if (psum_ready) begin
                    psum_take = 1'b1;
                    if (pos == LAST_POS) begin
`ifdef IFMAP_FWD_EN
                        state_nx = S_FWD;
`else
                        pass_end = 1'b1;
                        state_nx = S_IDLE;
`endif
                    end else begin
                        state_nx = S_MAC;
                    end
                end
            end
`ifdef IFMAP_FWD_EN
            S_FWD: begin
                fwd_valid = 1'b1;
                if (fwd_ready) begin
                    pass_end = 1'b1;
                    state_nx = S_IDLE;
                end
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Control and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            pos         <= '0;
            tap         <= '0;
            dst_cnt     <= '0;
            filt_loaded <= 1'b0;
            row_done    <= 1'b0;
            out_en      <= 1'b0;
        end else begin
            out_en   <= 1'b1;
            row_done <= pass_end;
            if (filt_take) begin
                filt_loaded <= 1'b1;
            end
            if (ifmap_take) begin
                acc <= '0;
                pos <= '0;
                tap <= '0;
            end
            if (state == S_MAC) begin
                acc <= acc + tap_term(spike, weight[tap]);
                tap <= (tap == LAST_TAP) ? '0 : tap + 1'b1;
            end
            if (psum_take) begin
                acc     <= '0;
                pos     <= pos + 1'b1;
                dst_cnt <= (dst_cnt == LAST_DST) ? '0 : dst_cnt + 1'b1;
            end
        end
    end

    // Filter and ifmap row storage (data only, no reset)
    always_ff @(posedge clk) begin
        if (filt_take) begin
            for (int k = 0; k < FILT_TAPS; k++) begin
                weight[k] <= filt_data[k*W_WIDTH +: W_WIDTH];
            end
        end
        if (ifmap_take) begin
            row_q <= ifmap_data;
        end
    end

    assign psum_data = psum_valid ? acc : '0;
    assign psum_dst  = psum_valid ? dst_lookup(dst_cnt) : '0;
    assign psum_src  = PE_ADDR;

`ifdef IFMAP_FWD_EN
    assign fwd_data = fwd_valid ? row_q : '0;
`else
    assign fwd_data = '0;
    logic unused_fwd_ready;
    assign unused_fwd_ready = fwd_ready;
`endif

endmodule
